// File: rtl/block_update_ctrl_pkg.sv
// rtl/block_update_ctrl_pkg.sv - shared tile codes, geometry defaults and FSM types
package block_update_ctrl_pkg;

  localparam int TILE_PX  = 40;
  localparam int ROWS_VIS = 12;

  localparam logic [5:0] T_B  = 6'd0;
  localparam logic [5:0] T_D  = 6'd3;
  localparam logic [5:0] T_J  = 6'd9;
  localparam logic [5:0] T_GY = 6'd28;
  localparam logic [5:0] T_DY = 6'd34;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_EVAL = 2'd2,
    S_WR   = 2'd3
  } state_t;

  typedef enum logic {
    SRC_BODY = 1'b0,
    SRC_HEAD = 1'b1
  } src_t;

endpackage

// File: rtl/block_rule.sv
// rtl/block_rule.sv - combinational tile rewrite rule for head bumps and body touches
import block_update_ctrl_pkg::*;

module block_rule #(
  parameter int TILE = TILE_PX
) (
  input  logic [5:0] tile,
  input  src_t       source,
  input  logic [9:0] sub,
  input  logic       dir,
  output logic [5:0] new_tile,
  output logic       write,
  output logic       point,
  output logic       bump
);

  localparam logic [9:0] HALF = 10'(TILE / 2);

  logic facing;

  // Head hits only count on the half of the tile the player faces; GY ignores facing and source
  always_comb begin
    facing   = (sub < HALF) ? ~dir : dir;
    new_tile = tile;
    write    = 1'b0;
    point    = 1'b0;
    bump     = 1'b0;
    if (tile == T_GY) begin
      new_tile = T_B;
      write    = 1'b1;
      point    = 1'b1;
    end else if (source == SRC_HEAD && facing) begin
      if (tile == T_D) begin
        new_tile = T_DY;
        write    = 1'b1;
        point    = 1'b1;
        bump     = 1'b1;
      end else if (tile == T_J) begin
        new_tile = T_B;
        write    = 1'b1;
        bump     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/block_update_ctrl.sv
// rtl/block_update_ctrl.sv - arbitrates head/body map requests, rewrites tiles, drives bump animation
import block_update_ctrl_pkg::*;

module block_update_ctrl #(
  parameter int TILE = TILE_PX,
  parameter int ROWS = ROWS_VIS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       head_req,
  input  logic [9:0] head_xpos,
  input  logic [8:0] head_ypos,
  input  logic       head_dir,
  output logic       head_ack,
  input  logic       body_req,
  input  logic [9:0] body_xpos,
  input  logic [8:0] body_ypos,
  output logic       body_ack,
  output logic [8:0] map_addr,
  input  logic [5:0] map_rdata,
  output logic [5:0] map_wdata,
  output logic       map_we,
  input  logic       frame_tick,
  output logic       new_point,
  output logic       bump_active,
  output logic [8:0] bump_addr,
  output logic [2:0] bump_offset,
  output logic       busy
);

  localparam logic [9:0] Y_LIMIT = 10'(ROWS * TILE);

  state_t     state, state_nxt;
  src_t       lat_src;
  logic [9:0] lat_x;
  logic [8:0] lat_y;
  logic       lat_dir;
  logic       lat_oor;
  logic [3:0] cnt;

  logic       req_any;
  logic [8:0] in_y;
  logic       in_oor;
  logic [4:0] col;
  logic [3:0] row;
  logic [9:0] sub;
  logic       ack_cycle;

  logic [5:0] rule_tile;
  logic       rule_write;
  logic       rule_point;
  logic       rule_bump;

  assign req_any  = head_req | body_req;
  assign in_y     = head_req ? head_ypos : body_ypos;
  assign in_oor   = {1'b0, in_y} >= Y_LIMIT;

  assign col      = 5'(lat_x / 10'(TILE));
  assign row      = 4'(lat_y / 9'(TILE));
  assign sub      = lat_x % 10'(TILE);
  assign map_addr = {row, col};

  assign busy      = (state != S_IDLE);
  assign ack_cycle = (state == S_RD) || (state == S_WR && lat_oor);
  assign head_ack  = ack_cycle && (lat_src == SRC_HEAD);
  assign body_ack  = ack_cycle && (lat_src == SRC_BODY);

  assign bump_offset = cnt[3] ? ~cnt[2:0] : cnt[2:0];

  block_rule #(.TILE(TILE)) u_rule (
    .tile     (map_rdata),
    .source   (lat_src),
    .sub      (sub),
    .dir      (lat_dir),
    .new_tile (rule_tile),
    .write    (rule_write),
    .point    (rule_point),
    .bump     (rule_bump)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state: off-screen requests jump straight to WR so the ack still gets its one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_any) state_nxt = in_oor ? S_WR : S_RD;
      S_RD:    state_nxt = S_EVAL;
      S_EVAL:  state_nxt = S_WR;
      S_WR:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Latch the winning request at acceptance; head has priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_src <= SRC_BODY;
      lat_x   <= '0;
      lat_y   <= '0;
      lat_dir <= 1'b0;
      lat_oor <= 1'b0;
    end else if (state == S_IDLE && req_any) begin
      lat_src <= head_req ? SRC_HEAD : SRC_BODY;
      lat_x   <= head_req ? head_xpos : body_xpos;
      lat_y   <= in_y;
      lat_dir <= head_req & head_dir;
      lat_oor <= in_oor;
    end
  end

  // Register the rule result in EVAL so the write and score pulse land together in WR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      map_we    <= 1'b0;
      new_point <= 1'b0;
      map_wdata <= '0;
    end else begin
      map_we    <= (state == S_EVAL) && rule_write;
      new_point <= (state == S_EVAL) && rule_point;
      if (state == S_EVAL) map_wdata <= rule_tile;
    end
  end

  // Bump animation: restart on any head D/J rewrite, step once per frame, stop after 16 frames
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bump_active <= 1'b0;
      bump_addr   <= '0;
      cnt         <= '0;
    end else if (state == S_EVAL && rule_bump) begin
      bump_active <= 1'b1;
      bump_addr   <= map_addr;
      cnt         <= '0;
    end else if (bump_active && frame_tick) begin
      cnt <= cnt + 4'd1;
      if (cnt == 4'd15) bump_active <= 1'b0;
    end
  end

endmodule

// File: tb/tb_block_update_ctrl.sv
// tb/tb_block_update_ctrl.sv - self-checking bench for block_update_ctrl
module tb_block_update_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       head_req = 1'b0;
  logic [9:0] head_xpos = '0;
  logic [8:0] head_ypos = '0;
  logic       head_dir = 1'b0;
  logic       head_ack;
  logic       body_req = 1'b0;
  logic [9:0] body_xpos = '0;
  logic [8:0] body_ypos = '0;
  logic       body_ack;
  logic [8:0] map_addr;
  logic [5:0] map_rdata = '0;
  logic [5:0] map_wdata;
  logic       map_we;
  logic       frame_tick = 1'b0;
  logic       new_point;
  logic       bump_active;
  logic [8:0] bump_addr;
  logic [2:0] bump_offset;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [5:0] mem [0:511];
  logic       pre_we = 1'b0;
  logic [8:0] pre_addr = '0;
  logic [5:0] pre_data = '0;

  block_update_ctrl dut (
    .clk(clk), .rst(rst),
    .head_req(head_req), .head_xpos(head_xpos), .head_ypos(head_ypos), .head_dir(head_dir), .head_ack(head_ack),
    .body_req(body_req), .body_xpos(body_xpos), .body_ypos(body_ypos), .body_ack(body_ack),
    .map_addr(map_addr), .map_rdata(map_rdata), .map_wdata(map_wdata), .map_we(map_we),
    .frame_tick(frame_tick), .new_point(new_point), .bump_active(bump_active),
    .bump_addr(bump_addr), .bump_offset(bump_offset), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (map_we) mem[map_addr] <= map_wdata;
    map_rdata <= mem[map_addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic poke(input int a, input int d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = 9'(a); pre_data = 6'(d);
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Reference: playfield rules in plain arithmetic
  task automatic ref_model(input bit head, input int x, input int y, input bit dir, input int tile,
                           output bit wr, output int nt, output bit pt, output bit bump, output int addr);
    int  sub;
    bit  toward;
    wr = 0; pt = 0; bump = 0; nt = tile;
    addr = (y / 40) * 32 + (x / 40);
    if (y >= 12 * 40) return;
    sub = x % 40;
    toward = (sub < 20 && !dir) || (sub >= 20 && dir);
    if (tile == 28) begin wr = 1; nt = 0; pt = 1; end
    else if (head && toward && tile == 3) begin wr = 1; nt = 34; pt = 1; bump = 1; end
    else if (head && toward && tile == 9) begin wr = 1; nt = 0; bump = 1; end
  endtask

  task automatic run_req(input bit head, input int x, input int y, input bit dir,
                         output int ack_c, output int we_c, output int wd, output bit pt,
                         output int wa, output int stray, output int idle_c, output int rd_addr);
    ack_c = -1; we_c = -1; wd = 0; pt = 0; wa = 0; stray = 0; idle_c = -1; rd_addr = 0;
    if (head) begin
      head_req = 1; head_xpos = 10'(x); head_ypos = 9'(y); head_dir = dir;
    end else begin
      body_req = 1; body_xpos = 10'(x); body_ypos = 9'(y);
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if ((head ? head_ack : body_ack) && ack_c < 0) begin
        ack_c = c; rd_addr = int'(map_addr);
        head_req = 0; body_req = 0;
      end
      if (map_we) begin
        we_c = c; wd = int'(map_wdata); pt = new_point; wa = int'(map_addr);
      end else if (new_point) stray++;
      if (!busy && idle_c < 0) idle_c = c;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1 rst = 1;
    @(negedge clk);
    checks++;
    if ({busy, map_we, head_ack, body_ack, new_point, bump_active} !== 6'b0 ||
        map_addr !== 9'd0 || map_wdata !== 6'd0 || bump_addr !== 9'd0 || bump_offset !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0d we=%0d addr=%0d wdata=%0d bact=%0d baddr=%0d boff=%0d, want all 0",
               busy, map_we, map_addr, map_wdata, bump_active, bump_addr, bump_offset);
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || map_we !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle: busy=%0d we=%0d, want 0 0", busy, map_we);
    end
  endtask

  task automatic test_head_dy();
    int ack_c, we_c, wd, wa, stray, idle_c, rd_a; bit pt; int want;
    poke(98, 3);
    run_req(1, 85, 120, 0, ack_c, we_c, wd, pt, wa, stray, idle_c, rd_a);
    checks++; if (ack_c !== 1) begin errors++; $display("FAIL dy_ack_cycle: got %0d want 1", ack_c); end
    checks++; if (rd_a !== 98) begin errors++; $display("FAIL dy_rd_addr: got %0d want 98", rd_a); end
    checks++; if (we_c !== 3) begin errors++; $display("FAIL dy_we_cycle: got %0d want 3", we_c); end
    checks++; if (wd !== 34 || wa !== 98) begin errors++; $display("FAIL dy_write: got data %0d addr %0d want 34 98", wd, wa); end
    checks++; if (pt !== 1'b1 || stray !== 0) begin errors++; $display("FAIL dy_point: got %0d stray %0d want 1 0", pt, stray); end
    checks++; if (idle_c !== 4) begin errors++; $display("FAIL dy_idle_cycle: got %0d want 4", idle_c); end
    checks++; if (mem[98] !== 6'd34) begin errors++; $display("FAIL dy_mem: got %0d want 34", mem[98]); end
    checks++;
    if (bump_active !== 1'b1 || bump_addr !== 9'd98 || bump_offset !== 3'd0) begin
      errors++; $display("FAIL dy_bump_start: act %0d addr %0d off %0d want 1 98 0", bump_active, bump_addr, bump_offset);
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk); frame_tick = 1;
      @(negedge clk); frame_tick = 0;
      want = (k < 15 - k) ? k : 15 - k;
      checks++;
      if (k < 16 && (bump_active !== 1'b1 || int'(bump_offset) !== want)) begin
        errors++; $display("FAIL bump_tick%0d: act %0d off %0d want 1 %0d", k, bump_active, bump_offset, want);
      end else if (k == 16 && bump_active !== 1'b0) begin
        errors++; $display("FAIL bump_end: act %0d want 0", bump_active);
      end
    end
  endtask

  task automatic test_wrong_facing();
    int ack_c, we_c, wd, wa, stray, idle_c, rd_a; bit pt;
    poke(98, 3);
    run_req(1, 85, 120, 1, ack_c, we_c, wd, pt, wa, stray, idle_c, rd_a);
    checks++; if (ack_c !== 1) begin errors++; $display("FAIL facing_ack: got %0d want 1", ack_c); end
    checks++; if (we_c !== -1 || stray !== 0) begin errors++; $display("FAIL facing_nowrite: we cycle %0d stray %0d want -1 0", we_c, stray); end
    checks++; if (bump_active !== 1'b0 || mem[98] !== 6'd3) begin errors++; $display("FAIL facing_state: bump %0d mem %0d want 0 3", bump_active, mem[98]); end
  endtask

  task automatic test_priority();
    int h_ack = -1, b_ack = -1, b_we = -1, n_we = 0, wd = 0, wa = 0; bit pt = 0;
    poke(98, 5);
    poke(167, 28);
    head_req = 1; head_xpos = 85; head_ypos = 120; head_dir = 0;
    body_req = 1; body_xpos = 300; body_ypos = 200;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (head_ack && h_ack < 0) begin h_ack = c; head_req = 0; end
      if (body_ack && b_ack < 0) begin b_ack = c; body_req = 0; end
      if (map_we) begin n_we++; b_we = c; wd = int'(map_wdata); wa = int'(map_addr); pt = new_point; end
    end
    checks++; if (h_ack !== 1) begin errors++; $display("FAIL prio_head_ack: got %0d want 1", h_ack); end
    checks++; if (b_ack !== 5) begin errors++; $display("FAIL prio_body_ack: got %0d want 5", b_ack); end
    checks++; if (n_we !== 1 || b_we !== 7) begin errors++; $display("FAIL prio_body_we: count %0d cycle %0d want 1 7", n_we, b_we); end
    checks++; if (wd !== 0 || wa !== 167 || pt !== 1'b1) begin errors++; $display("FAIL prio_body_write: data %0d addr %0d pt %0d want 0 167 1", wd, wa, pt); end
  endtask

  task automatic test_j_break();
    int ack_c, we_c, wd, wa, stray, idle_c, rd_a; bit pt;
    poke(34, 9);
    run_req(1, 100, 40, 1, ack_c, we_c, wd, pt, wa, stray, idle_c, rd_a);
    checks++; if (we_c !== 3 || wd !== 0 || wa !== 34) begin errors++; $display("FAIL j_write: cycle %0d data %0d addr %0d want 3 0 34", we_c, wd, wa); end
    checks++; if (pt !== 1'b0 || stray !== 0) begin errors++; $display("FAIL j_point: got %0d stray %0d want 0 0", pt, stray); end
    checks++; if (bump_active !== 1'b1 || bump_addr !== 9'd34) begin errors++; $display("FAIL j_bump: act %0d addr %0d want 1 34", bump_active, bump_addr); end
  endtask

  task automatic test_offscreen();
    int ack_c, we_c, wd, wa, stray, idle_c, rd_a; bit pt;
    run_req(0, 10, 490, 0, ack_c, we_c, wd, pt, wa, stray, idle_c, rd_a);
    checks++; if (ack_c !== 1) begin errors++; $display("FAIL oor_ack: got %0d want 1", ack_c); end
    checks++; if (we_c !== -1 || stray !== 0) begin errors++; $display("FAIL oor_nowrite: we %0d stray %0d want -1 0", we_c, stray); end
    checks++; if (idle_c !== 2) begin errors++; $display("FAIL oor_idle: got %0d want 2", idle_c); end
  endtask

  task automatic test_reset_mid();
    int ack_c = -1, we_c = -1, wd = 0, early_we = 0;
    poke(98, 3);
    head_req = 1; head_xpos = 85; head_ypos = 120; head_dir = 0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      if (map_we) early_we++;
    end
    #1 rst = 1;
    #1;
    checks++;
    if ({busy, map_we, head_ack, new_point, bump_active} !== 5'b0 || map_addr !== 9'd0) begin
      errors++; $display("FAIL midrst_outputs: busy %0d we %0d ack %0d bact %0d addr %0d want 0", busy, map_we, head_ack, bump_active, map_addr);
    end
    @(negedge clk);
    if (map_we) early_we++;
    checks++; if (early_we !== 0 || mem[98] !== 6'd3) begin errors++; $display("FAIL midrst_nowrite: we %0d mem %0d want 0 3", early_we, mem[98]); end
    rst = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (head_ack && ack_c < 0) begin ack_c = c; head_req = 0; end
      if (map_we) begin we_c = c; wd = int'(map_wdata); end
    end
    checks++; if (ack_c !== 1 || we_c !== 3 || wd !== 34) begin errors++; $display("FAIL midrst_reserve: ack %0d we %0d data %0d want 1 3 34", ack_c, we_c, wd); end
  endtask

  task automatic test_random();
    int codes [6] = '{0, 3, 9, 28, 34, 5};
    int ack_c, we_c, wd, wa, stray, idle_c, rd_a; bit pt;
    bit ewr, ept, ebump; int ent, eaddr;
    for (int i = 0; i < 40; i++) begin
      bit head = 1'($urandom);
      bit dir  = 1'($urandom);
      int x    = int'($urandom_range(0, 1023));
      int y    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(480, 511)) : int'($urandom_range(0, 479));
      int tile = codes[$urandom_range(0, 5)];
      ref_model(head, x, y, dir, tile, ewr, ent, ept, ebump, eaddr);
      if (y < 480) poke(eaddr, tile);
      else @(negedge clk);
      run_req(head, x, y, dir, ack_c, we_c, wd, pt, wa, stray, idle_c, rd_a);
      checks++;
      if (ack_c !== 1 || idle_c !== ((y >= 480) ? 2 : 4)) begin
        errors++; $display("FAIL rnd%0d_handshake: ack %0d idle %0d", i, ack_c, idle_c);
      end
      checks++;
      if (we_c !== (ewr ? 3 : -1) || stray !== 0) begin
        errors++; $display("FAIL rnd%0d_we: got cycle %0d want %0d (h%0d x%0d y%0d d%0d t%0d)", i, we_c, ewr ? 3 : -1, head, x, y, dir, tile);
      end
      if (ewr) begin
        checks++;
        if (wd !== ent || wa !== eaddr || pt !== ept) begin
          errors++; $display("FAIL rnd%0d_data: got %0d@%0d pt%0d want %0d@%0d pt%0d", i, wd, wa, pt, ent, eaddr, ept);
        end
      end
      if (ebump) begin
        checks++;
        if (bump_active !== 1'b1 || int'(bump_addr) !== eaddr || bump_offset !== 3'd0) begin
          errors++; $display("FAIL rnd%0d_bump: act %0d addr %0d off %0d want 1 %0d 0", i, bump_active, bump_addr, bump_offset, eaddr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_head_dy();
    test_wrong_facing();
    test_priority();
    test_j_break();
    test_offscreen();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/block_update_ctrl.md
BLOCK_UPDATE_CTRL -- requirements
Module: block_update_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; rst  in  1  asynchronous active-high reset.
REQ-002 SHALL have ports: head_req  in  1  head-bump request; head_xpos  in  10  pixel x; head_ypos  in  9  pixel y; head_dir  in  1  facing (0 left, 1 right); head_ack  out  1  accept pulse.
REQ-003 SHALL have ports: body_req  in  1  body-touch request; body_xpos  in  10; body_ypos  in  9; body_ack  out  1  accept pulse.
REQ-004 SHALL have ports: map_addr  out  9  {row[3:0], col[4:0]}; map_rdata  in  6  tile code, one-cycle synchronous read; map_wdata  out  6; map_we  out  1.
REQ-005 SHALL have ports: frame_tick  in  1  one pulse per video frame; new_point  out  1  score pulse; bump_active  out  1; bump_addr  out  9; bump_offset  out  3  upward pixel lift; busy  out  1.
REQ-006 SHALL use one clock; reset is asynchronous and active-high.
REQ-007 SHALL use parameters: TILE = 40, default 40, tile edge in pixels; ROWS = 12, default 12, visible rows.

Function
REQ-008 SHALL implement FSM IDLE -> RD -> EVAL -> WR -> IDLE; busy = 1 in every state except IDLE.
REQ-009 In IDLE, head_req SHALL win over body_req when both are high; the loser stays pending and is served on the next IDLE.
REQ-010 On acceptance, SHALL latch x, y, dir and source (head/body; body uses up=0, dir ignored), and pulse the matching ack for exactly the first RD cycle.
REQ-011 Requesters SHALL hold req and inputs until ack; req deasserted before acceptance is not served.
REQ-012 SHALL compute col = x / TILE, row = y / TILE, sub = x % TILE from latched values.
REQ-013 If y >= ROWS*TILE: SHALL ack, skip RD/EVAL, and return to IDLE with no write, no point, and no bump.
REQ-014 RD SHALL drive map_addr; EVAL SHALL capture map_rdata and evaluate the rule (REQ-015..017); WR SHALL assert map_we for one cycle only if a rewrite applies.
REQ-015 Tile GY (28) SHALL become B (0) with new_point, for either source, regardless of sub or dir.
REQ-016 Head source only, gated by (sub < 20 and dir = 0) or (sub >= 20 and dir = 1): D (3) becomes DY (34) with new_point; J (9) becomes B (0) without a point.
REQ-017 All other cases SHALL produce no write and no point.
REQ-018 new_point SHALL pulse for one cycle, coincident with the map_we of its rewrite.
REQ-019 Request-to-write latency SHALL be 3 cycles (accept edge, RD, EVAL, WR); the earliest next acceptance is the cycle after WR.
REQ-020 A head rewrite of D or J SHALL start the bump: bump_addr = written address; 4-bit counter cnt = 0; bump_active = 1.
REQ-021 cnt SHALL increment on frame_tick while active; bump_offset = cnt[2:0] for cnt < 8, else 15 - cnt; bump_active clears when cnt increments past 15.
REQ-022 A new bump while one is active SHALL restart the bump with the new address; the bump runs independently of the FSM.
REQ-023 map_wdata SHALL hold the last evaluated value; it is meaningful only when map_we = 1.

Reset
REQ-024 rst SHALL force, asynchronously: state IDLE; head_ack, body_ack, map_we, new_point, bump_active, busy = 0; map_addr, map_wdata, bump_addr, bump_offset, cnt = 0; latched request cleared.
REQ-025 Reset during any state SHALL abort the operation with no write; after release, still-high requests are re-arbitrated.

Structure
REQ-026 Tile code constants (B, D, J, GY, DY, ...) and TILE SHALL live in a shared package used by all map-touching blocks.
REQ-027 The rewrite rule SHALL be one combinational sub-module, block_rule (tile, source, sub, dir -> new tile, write, point), instantiated in EVAL.

Verification
REQ-028 Head req x=85, y=120, dir=0, tile D -> addr {3,2}, map_we with wdata 34 three cycles after accept, new_point = 1, bump_offset sequence 0..7,7..0 over 16 frame_ticks.
REQ-029 Head req x=85, dir=1, tile D (sub 5) -> no map_we, no point, no bump; head_ack still pulses.
REQ-030 head_req and body_req high together, body tile GY -> head served first; body_ack follows the head's WR; body write 0 with new_point.
REQ-031 Head req, tile J, x=100, dir=1 (sub 20) -> wdata 0, map_we = 1, new_point = 0, bump starts.
REQ-032 Body req y=490 -> ack, no map access, busy returns to 0 the next cycle.
REQ-033 rst asserted during EVAL -> outputs zero immediately, no map_we ever; held request is re-served after release.
